// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module  : time_keeper
// Brief   : HH:MM:SS timekeeper with a 1 Hz prescaler and a RUN/SET_HOUR/SET_MIN
//           set mode. Define TWELVE_HOUR_EN for a 1..12 hour range with a pm flag.
// Rev     : 1.0
// ============================================================================
module time_keeper #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hour,
    output logic       pm,
    output logic       tick_1hz,
    output logic [1:0] set_state
);

    localparam int                 C_PRE_W   = $clog2(CLK_HZ);
    localparam logic [C_PRE_W-1:0] C_PRE_TOP = C_PRE_W'(CLK_HZ - 1);

`ifdef TWELVE_HOUR_EN
    localparam logic [5:0] C_HOUR_RST = 6'd12;
    localparam logic [5:0] C_HOUR_MIN = 6'd1;
    localparam logic [5:0] C_HOUR_MAX = 6'd12;
`else
    localparam logic [5:0] C_HOUR_RST = 6'd0;
    localparam logic [5:0] C_HOUR_MIN = 6'd0;
    localparam logic [5:0] C_HOUR_MAX = 6'd23;
`endif

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t             r_state;
    logic [C_PRE_W-1:0] r_prescale;
    logic [C_PRE_W-1:0] w_prescale_nxt;
    logic [5:0]         w_hour_inc;
    logic [5:0]         w_min_inc;
    logic               w_pm_flip;

    assign w_prescale_nxt = (r_prescale == C_PRE_TOP) ? '0 : r_prescale + C_PRE_W'(1);
    assign w_hour_inc     = (hour == C_HOUR_MAX) ? C_HOUR_MIN : hour + 6'd1;
    assign w_min_inc      = (min == 6'd59) ? 6'd0 : min + 6'd1;
    assign set_state      = r_state;

    // Only a running carry from 11 into 12 flips the half-day; setting never does.
`ifdef TWELVE_HOUR_EN
    assign w_pm_flip = (hour == 6'd11);
`else
    assign w_pm_flip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_prescale <= '0;
            tick_1hz   <= 1'b0;
            sec        <= 6'd0;
            min        <= 6'd0;
            hour       <= C_HOUR_RST;
            pm         <= 1'b0;
        end else begin
            tick_1hz <= 1'b0;
            if (mode_btn) begin
                // Any state change restarts the second so RUN re-entry gets a full period.
                r_prescale <= '0;
                case (r_state)
                    RUN: begin
                        r_state <= SET_HOUR;
                        sec     <= 6'd0;
                    end
                    SET_HOUR: r_state <= SET_MIN;
                    default:  r_state <= RUN;
                endcase
            end else begin
                case (r_state)
                    RUN: begin
                        r_prescale <= w_prescale_nxt;
                        tick_1hz   <= (w_prescale_nxt == C_PRE_TOP);
                        if (tick_1hz) begin
                            if (sec == 6'd59) begin
                                sec <= 6'd0;
                                if (min == 6'd59) begin
                                    min  <= 6'd0;
                                    hour <= w_hour_inc;
                                    if (w_pm_flip) begin
                                        pm <= ~pm;
                                    end
                                end else begin
                                    min <= min + 6'd1;
                                end
                            end else begin
                                sec <= sec + 6'd1;
                            end
                        end
                    end
                    SET_HOUR: begin
                        if (inc_btn) begin
                            hour <= w_hour_inc;
                        end
                    end
                    default: begin
                        if (inc_btn) begin
                            min <= w_min_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// tb_time_keeper: directed scenarios plus randomized button traffic, checked
// against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int CLK_HZ = 4;
`ifdef TWELVE_HOUR_EN
    localparam bit TWELVE   = 1'b1;
    localparam int RST_HOUR = 12;
`else
    localparam bit TWELVE   = 1'b0;
    localparam int RST_HOUR = 0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn  = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic       pm;
    logic       tick_1hz;
    logic [1:0] set_state;

    int checks = 0;
    int errors = 0;

    // reference model: state 0/1/2, displayed fields, expected tick, edges since RUN start
    int m_st, m_h, m_m, m_s, m_cnt;
    bit m_pm, m_tick;

    time_keeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .pm        (pm),
        .tick_1hz  (tick_1hz),
        .set_state (set_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_st = 0; m_h = RST_HOUR; m_m = 0; m_s = 0; m_cnt = 0;
        m_pm = 1'b0; m_tick = 1'b0;
    endtask

    // advance wall-clock time by one second using seconds-of-day arithmetic
    task automatic model_second();
        int h24, tod;
        h24 = TWELVE ? ((m_h % 12) + (m_pm ? 12 : 0)) : m_h;
        tod = (h24 * 3600 + m_m * 60 + m_s + 1) % 86400;
        h24 = tod / 3600;
        m_m = (tod / 60) % 60;
        m_s = tod % 60;
        if (TWELVE) begin
            m_h  = (h24 % 12 == 0) ? 12 : h24 % 12;
            m_pm = (h24 >= 12);
        end else begin
            m_h = h24;
        end
    endtask

    task automatic model_edge(input logic m, input logic i);
        if (m) begin
            m_tick = 1'b0;
            m_cnt  = 0;
            if (m_st == 0) begin
                m_st = 1;
                m_s  = 0;
            end else if (m_st == 1) begin
                m_st = 2;
            end else begin
                m_st = 0;
            end
        end else if (m_st == 0) begin
            if (m_tick) model_second();
            m_cnt++;
            m_tick = (m_cnt % CLK_HZ == CLK_HZ - 1);
        end else if (i) begin
            if (m_st == 1) m_h = TWELVE ? (m_h % 12) + 1 : (m_h + 1) % 24;
            else           m_m = (m_m + 1) % 60;
        end
    endtask

    // one clock with the given buttons; returns at the following falling edge
    task automatic step(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        @(posedge clk);
        model_edge(m, i);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        @(negedge clk);
    endtask

    task automatic preset(input int h, input int mm);
        for (int n = 0; n < CLK_HZ && m_tick; n++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int n = 0; n < 24 && m_h != h; n++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int n = 0; n < 60 && m_m != mm; n++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
    endtask

    task automatic run_to_sec(input int s);
        for (int n = 0; n < CLK_HZ * 61 && m_s != s; n++) step(1'b0, 1'b0);
    endtask

    task automatic run_one_tick();
        for (int n = 0; n <= CLK_HZ && !m_tick; n++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b1);
        checks++;
        if (min !== 6'd30 || set_state !== 2'b10) begin
            errors++;
            $display("FAIL preset_min30: min=%0d state=%0d, want min=30 state=2", min, set_state);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (set_state !== 2'b00 || sec !== 6'd0 || min !== 6'd0 || hour !== 6'(RST_HOUR)
            || tick_1hz !== 1'b0 || pm !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d %0d:%0d:%0d tick=%0b pm=%0b, want 0 %0d:0:0 tick=0 pm=0",
                     set_state, hour, min, sec, tick_1hz, pm, RST_HOUR);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tick_rate();
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (tick_1hz !== (k % CLK_HZ == CLK_HZ - 1)) begin
                errors++;
                $display("FAIL tick_rate edge %0d: tick=%0b want %0b", k, tick_1hz, (k % CLK_HZ == CLK_HZ - 1));
            end
            checks++;
            if (sec !== 6'(k / CLK_HZ)) begin
                errors++;
                $display("FAIL tick_sec edge %0d: sec=%0d want %0d", k, sec, k / CLK_HZ);
            end
        end
    endtask

    task automatic test_set_mode();
        step(1'b1, 1'b0);
        checks++;
        if (set_state !== 2'b01 || sec !== 6'd0) begin
            errors++;
            $display("FAIL enter_set_hour: state=%0d sec=%0d, want state=1 sec=0", set_state, sec);
        end
        repeat (25) step(1'b0, 1'b1);
        checks++;
        if (hour !== 6'd1) begin
            errors++;
            $display("FAIL hour_25_inc: hour=%0d want 1", hour);
        end
        step(1'b1, 1'b0);
        checks++;
        if (set_state !== 2'b10) begin
            errors++;
            $display("FAIL enter_set_min: state=%0d want 2", set_state);
        end
        repeat (59) step(1'b0, 1'b1);
        checks++;
        if (min !== 6'd59) begin
            errors++;
            $display("FAIL min_preset59: min=%0d want 59", min);
        end
        step(1'b0, 1'b1);
        checks++;
        if (min !== 6'd0 || hour !== 6'd1) begin
            errors++;
            $display("FAIL min_wrap: %0d:%0d want 1:0", hour, min);
        end
        step(1'b1, 1'b0);
        checks++;
        if (set_state !== 2'b00 || tick_1hz !== 1'b0) begin
            errors++;
            $display("FAIL back_to_run: state=%0d tick=%0b want 0/0", set_state, tick_1hz);
        end
        for (int k = 1; k <= CLK_HZ; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (tick_1hz !== (k == CLK_HZ - 1) || sec !== 6'(k / CLK_HZ)) begin
                errors++;
                $display("FAIL first_tick edge %0d: tick=%0b sec=%0d want %0b/%0d",
                         k, tick_1hz, sec, (k == CLK_HZ - 1), k / CLK_HZ);
            end
        end
    endtask

    task automatic test_rollover();
`ifdef TWELVE_HOUR_EN
        preset(11, 59);
        run_to_sec(59);
        checks++;
        if (hour !== 6'd11 || min !== 6'd59 || sec !== 6'd59 || pm !== 1'b0) begin
            errors++;
            $display("FAIL pre_noon: %0d:%0d:%0d pm=%0b want 11:59:59 pm=0", hour, min, sec, pm);
        end
        run_one_tick();
        checks++;
        if (hour !== 6'd12 || min !== 6'd0 || sec !== 6'd0 || pm !== 1'b1) begin
            errors++;
            $display("FAIL noon: %0d:%0d:%0d pm=%0b want 12:0:0 pm=1", hour, min, sec, pm);
        end
        preset(12, 59);
        run_to_sec(59);
        checks++;
        if (hour !== 6'd12 || min !== 6'd59 || sec !== 6'd59 || pm !== 1'b1) begin
            errors++;
            $display("FAIL pre_one: %0d:%0d:%0d pm=%0b want 12:59:59 pm=1", hour, min, sec, pm);
        end
        run_one_tick();
        checks++;
        if (hour !== 6'd1 || min !== 6'd0 || sec !== 6'd0 || pm !== 1'b1) begin
            errors++;
            $display("FAIL one_pm: %0d:%0d:%0d pm=%0b want 1:0:0 pm=1", hour, min, sec, pm);
        end
`else
        preset(23, 59);
        run_to_sec(59);
        checks++;
        if (hour !== 6'd23 || min !== 6'd59 || sec !== 6'd59) begin
            errors++;
            $display("FAIL pre_midnight: %0d:%0d:%0d want 23:59:59", hour, min, sec);
        end
        run_one_tick();
        checks++;
        if (hour !== 6'd0 || min !== 6'd0 || sec !== 6'd0 || pm !== 1'b0) begin
            errors++;
            $display("FAIL midnight: %0d:%0d:%0d pm=%0b want 0:0:0 pm=0", hour, min, sec, pm);
        end
        run_to_sec(59);
        checks++;
        if (hour !== 6'd0 || min !== 6'd0 || sec !== 6'd59) begin
            errors++;
            $display("FAIL pre_min_carry: %0d:%0d:%0d want 0:0:59", hour, min, sec);
        end
        run_one_tick();
        checks++;
        if (hour !== 6'd0 || min !== 6'd1 || sec !== 6'd0) begin
            errors++;
            $display("FAIL min_carry: %0d:%0d:%0d want 0:1:0", hour, min, sec);
        end
`endif
    endtask

    task automatic test_simultaneous();
        for (int n = 0; n < CLK_HZ && m_tick; n++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int n = 0; n < 24 && m_h != 5; n++) step(1'b0, 1'b1);
        checks++;
        if (hour !== 6'd5 || set_state !== 2'b01) begin
            errors++;
            $display("FAIL set_hour5: hour=%0d state=%0d want 5/1", hour, set_state);
        end
        step(1'b1, 1'b1);
        checks++;
        if (set_state !== 2'b10 || hour !== 6'd5) begin
            errors++;
            $display("FAIL mode_and_inc: state=%0d hour=%0d want 2/5", set_state, hour);
        end
        step(1'b1, 1'b0);
        checks++;
        if (set_state !== 2'b00) begin
            errors++;
            $display("FAIL sim_exit: state=%0d want 0", set_state);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1200; n++) begin
            logic rm;
            logic ri;
            rm = ($urandom_range(0, 39) == 0) && !m_tick;
            ri = ($urandom_range(0, 2) == 0);
            step(rm, ri);
            checks++;
            if (sec !== 6'(m_s) || min !== 6'(m_m) || hour !== 6'(m_h) || pm !== m_pm
                || tick_1hz !== m_tick || set_state !== 2'(m_st)) begin
                errors++;
                $display("FAIL random cyc %0d: got %0d:%0d:%0d pm=%0b tick=%0b st=%0d want %0d:%0d:%0d pm=%0b tick=%0b st=%0d",
                         n, hour, min, sec, pm, tick_1hz, set_state, m_h, m_m, m_s, m_pm, m_tick, m_st);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tick_rate();
        test_set_mode();
        test_rollover();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
